// File: rtl/falling_char_engine_if.sv
// Bundles the engine's control, spawn, keyboard, read-port and status signals.
// master: the side that drives the game (generator, keyboard, renderer index).
// slave: the falling_char_engine itself.
interface falling_char_engine_if #(
    parameter int unsigned IDX_W   = 4,
    parameter int unsigned X_W     = 10,
    parameter int unsigned Y_W     = 10,
    parameter int unsigned SCORE_W = 8
);
    logic               start;
    logic               spawn_valid;
    logic               spawn_ready;
    logic [7:0]         spawn_char;
    logic [X_W-1:0]     spawn_x;
    logic [2:0]         spawn_speed;
    logic               tick;
    logic               key_valid;
    logic [7:0]         key_char;
    logic [IDX_W-1:0]   rd_idx;
    logic               rd_active;
    logic [7:0]         rd_char;
    logic [X_W-1:0]     rd_x;
    logic [Y_W-1:0]     rd_y;
    logic [1:0]         state;
    logic [SCORE_W-1:0] score;
    logic [3:0]         lives;
    logic               hit;
    logic               miss;
    logic               game_over;

    modport master (
        output start, spawn_valid, spawn_char, spawn_x, spawn_speed, tick,
               key_valid, key_char, rd_idx,
        input  spawn_ready, rd_active, rd_char, rd_x, rd_y, state, score, lives,
               hit, miss, game_over
    );

    modport slave (
        input  start, spawn_valid, spawn_char, spawn_x, spawn_speed, tick,
               key_valid, key_char, rd_idx,
        output spawn_ready, rd_active, rd_char, rd_x, rd_y, state, score, lives,
               hit, miss, game_over
    );
endinterface

// File: rtl/falling_char_engine.sv
// Falling-character object engine: slot table, game FSM, spawn/descent/hit/miss,
// score and lives, plus a registered read port for the renderer.
module falling_char_engine #(
    parameter int unsigned N_SLOTS = 16,
    parameter int unsigned IDX_W   = 4,
    parameter int unsigned X_W     = 10,
    parameter int unsigned Y_W     = 10,
    parameter int unsigned BOTTOM  = 480,
    parameter int unsigned SCORE_W = 8,
    parameter int unsigned LIVES   = 3
) (
    input logic                  clk,
    input logic                  rst,
    falling_char_engine_if.slave bus
);
    localparam int unsigned YS_W  = Y_W + 1;
    localparam int unsigned CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {StIdle = 2'd0, StPlay = 2'd1, StOver = 2'd2} state_e;

    state_e               state_q, state_d;
    logic [N_SLOTS-1:0]   active_q, active_d;
    logic [7:0]           char_q  [N_SLOTS];
    logic [7:0]           char_d  [N_SLOTS];
    logic [X_W-1:0]       x_q     [N_SLOTS];
    logic [X_W-1:0]       x_d     [N_SLOTS];
    logic [Y_W-1:0]       y_q     [N_SLOTS];
    logic [Y_W-1:0]       y_d     [N_SLOTS];
    logic [2:0]           speed_q [N_SLOTS];
    logic [2:0]           speed_d [N_SLOTS];
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [3:0]           lives_q, lives_d;
    logic                 hit_q, hit_d, miss_q, miss_d;
    logic                 rd_active_q;
    logic [7:0]           rd_char_q;
    logic [X_W-1:0]       rd_x_q;
    logic [Y_W-1:0]       rd_y_q;

    logic                 any_free;
    logic [IDX_W-1:0]     free_idx;
    logic                 found;
    logic [IDX_W-1:0]     win_idx;
    logic [Y_W-1:0]       win_y;
    logic [YS_W-1:0]      sum;
    logic [CNT_W-1:0]     cross_cnt;

    // Lowest-index free slot, taken from registered occupancy only.
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!active_q[i]) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    // Key match winner: deepest matching slot, strict compare keeps the lowest index on ties.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        win_y   = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (active_q[i] && char_q[i] == bus.key_char && (!found || y_q[i] > win_y)) begin
                found   = 1'b1;
                win_idx = IDX_W'(i);
                win_y   = y_q[i];
            end
        end
    end

    // Next-state: FSM, hit removal, tick descent/miss, then spawn into the pre-cycle free slot.
    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        char_d    = char_q;
        x_d       = x_q;
        y_d       = y_q;
        speed_d   = speed_q;
        score_d   = score_q;
        lives_d   = lives_q;
        hit_d     = 1'b0;
        miss_d    = 1'b0;
        sum       = '0;
        cross_cnt = '0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d  = StPlay;
                    active_d = '0;
                    for (int i = 0; i < N_SLOTS; i++) begin
                        char_d[i]  = '0;
                        x_d[i]     = '0;
                        y_d[i]     = '0;
                        speed_d[i] = '0;
                    end
                    score_d = '0;
                    lives_d = 4'(LIVES);
                end
            end
            StPlay: begin
                if (bus.key_valid && found) begin
                    active_d[win_idx] = 1'b0;
                    hit_d             = 1'b1;
                    if (score_q != '1) score_d = score_q + SCORE_W'(1);
                end
                // The hit slot is already cleared in active_d, so it neither moves nor misses.
                if (bus.tick) begin
                    for (int i = 0; i < N_SLOTS; i++) begin
                        if (active_d[i]) begin
                            sum = {1'b0, y_q[i]} + YS_W'(speed_q[i]);
                            if (sum >= YS_W'(BOTTOM)) begin
                                active_d[i] = 1'b0;
                                cross_cnt   = cross_cnt + CNT_W'(1);
                            end else begin
                                y_d[i] = sum[Y_W-1:0];
                            end
                        end
                    end
                end
                if (cross_cnt != '0) begin
                    miss_d = 1'b1;
                    if (32'(cross_cnt) >= 32'(lives_q)) lives_d = '0;
                    else lives_d = lives_q - 4'(cross_cnt);
                end
                if (bus.spawn_valid && any_free) begin
                    active_d[free_idx] = 1'b1;
                    char_d[free_idx]   = bus.spawn_char;
                    x_d[free_idx]      = bus.spawn_x;
                    y_d[free_idx]      = '0;
                    speed_d[free_idx]  = (bus.spawn_speed == 3'd0) ? 3'd1 : bus.spawn_speed;
                end
                if (lives_d == 4'd0) state_d = StOver;
            end
            StOver: begin
                if (bus.start) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Game state and slot table registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            active_q <= '0;
            char_q   <= '{default: '0};
            x_q      <= '{default: '0};
            y_q      <= '{default: '0};
            speed_q  <= '{default: '0};
            score_q  <= '0;
            lives_q  <= 4'(LIVES);
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            char_q   <= char_d;
            x_q      <= x_d;
            y_q      <= y_d;
            speed_q  <= speed_d;
            score_q  <= score_d;
            lives_q  <= lives_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
        end
    end

    // Renderer read port: one-cycle latency, out-of-range index reads as empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_active_q <= 1'b0;
            rd_char_q   <= '0;
            rd_x_q      <= '0;
            rd_y_q      <= '0;
        end else if (32'(bus.rd_idx) < N_SLOTS) begin
            rd_active_q <= active_q[bus.rd_idx];
            rd_char_q   <= char_q[bus.rd_idx];
            rd_x_q      <= x_q[bus.rd_idx];
            rd_y_q      <= y_q[bus.rd_idx];
        end else begin
            rd_active_q <= 1'b0;
            rd_char_q   <= '0;
            rd_x_q      <= '0;
            rd_y_q      <= '0;
        end
    end

    assign bus.spawn_ready = (state_q == StPlay) && any_free;
    assign bus.state       = state_q;
    assign bus.score       = score_q;
    assign bus.lives       = lives_q;
    assign bus.hit         = hit_q;
    assign bus.miss        = miss_q;
    assign bus.game_over   = (state_q == StOver);
    assign bus.rd_active   = rd_active_q;
    assign bus.rd_char     = rd_char_q;
    assign bus.rd_x        = rd_x_q;
    assign bus.rd_y        = rd_y_q;
endmodule

// File: tb/tb_falling_char_engine.sv
// Bench for falling_char_engine: a slot-list game model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_falling_char_engine;
    logic clk;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    falling_char_engine_if #(.IDX_W(4), .X_W(10), .Y_W(10), .SCORE_W(8)) bus ();

    falling_char_engine #(
        .N_SLOTS(16), .IDX_W(4), .X_W(10), .Y_W(10), .BOTTOM(480), .SCORE_W(8), .LIVES(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit act;
        int ch;
        int x;
        int y;
        int sp;
    } slot_t;

    slot_t m [16];
    int    m_state, m_score, m_lives;
    bit    m_hit, m_miss;
    int    m_rd_act, m_rd_ch, m_rd_x, m_rd_y;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m[i] = '{act: 1'b0, ch: 0, x: 0, y: 0, sp: 0};
        m_state = 0; m_score = 0; m_lives = 3; m_hit = 0; m_miss = 0;
        m_rd_act = 0; m_rd_ch = 0; m_rd_x = 0; m_rd_y = 0;
    endfunction

    function automatic int model_ready();
        if (m_state != 1) return 0;
        for (int i = 0; i < 16; i++) if (!m[i].act) return 1;
        return 0;
    endfunction

    task automatic model_step();
        slot_t pre [16];
        int    free, win, n, idx, sp;
        pre  = m;
        idx  = int'(bus.rd_idx);
        m_rd_act = int'(pre[idx].act); m_rd_ch = pre[idx].ch;
        m_rd_x   = pre[idx].x;         m_rd_y  = pre[idx].y;
        m_hit = 0; m_miss = 0;
        case (m_state)
            0: if (bus.start) begin
                for (int i = 0; i < 16; i++) m[i] = '{act: 1'b0, ch: 0, x: 0, y: 0, sp: 0};
                m_state = 1; m_score = 0; m_lives = 3;
            end
            1: begin
                free = -1;
                for (int i = 15; i >= 0; i--) if (!pre[i].act) free = i;
                if (bus.key_valid) begin
                    win = -1;
                    for (int i = 0; i < 16; i++)
                        if (pre[i].act && pre[i].ch == int'(bus.key_char))
                            if (win < 0 || pre[i].y > pre[win].y) win = i;
                    if (win >= 0) begin
                        m[win].act = 1'b0;
                        m_hit = 1;
                        if (m_score < 255) m_score++;
                    end
                end
                if (bus.tick) begin
                    n = 0;
                    for (int i = 0; i < 16; i++) begin
                        if (m[i].act) begin
                            if (m[i].y + m[i].sp >= 480) begin
                                m[i].act = 1'b0;
                                n++;
                            end else begin
                                m[i].y = m[i].y + m[i].sp;
                            end
                        end
                    end
                    if (n > 0) begin
                        m_miss  = 1;
                        m_lives = (n >= m_lives) ? 0 : m_lives - n;
                    end
                end
                if (bus.spawn_valid && free >= 0) begin
                    sp = (bus.spawn_speed == 3'd0) ? 1 : int'(bus.spawn_speed);
                    m[free] = '{act: 1'b1, ch: int'(bus.spawn_char), x: int'(bus.spawn_x),
                                y: 0, sp: sp};
                end
                if (m_lives == 0) m_state = 2;
            end
            2: if (bus.start) m_state = 0;
            default: m_state = 0;
        endcase
    endtask

    // Advance the model on each rising edge and compare all outputs shortly after.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst) model_reset();
            else model_step();
            #1;
            chk("model state",       32'(bus.state),       m_state);
            chk("model score",       32'(bus.score),       m_score);
            chk("model lives",       32'(bus.lives),       m_lives);
            chk("model hit",         32'(bus.hit),         32'(m_hit));
            chk("model miss",        32'(bus.miss),        32'(m_miss));
            chk("model game_over",   32'(bus.game_over),   (m_state == 2) ? 1 : 0);
            chk("model spawn_ready", 32'(bus.spawn_ready), model_ready());
            chk("model rd_active",   32'(bus.rd_active),   m_rd_act);
            chk("model rd_char",     32'(bus.rd_char),     m_rd_ch);
            chk("model rd_x",        32'(bus.rd_x),        m_rd_x);
            chk("model rd_y",        32'(bus.rd_y),        m_rd_y);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus helpers (all start and end at a falling edge) ----------------
    task automatic pulse_start();
        bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
    endtask

    task automatic spawn(input logic [7:0] c, input int x, input int sp);
        bus.spawn_valid = 1'b1; bus.spawn_char = c;
        bus.spawn_x = 10'(x); bus.spawn_speed = 3'(sp);
        @(negedge clk);
        bus.spawn_valid = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            bus.tick = 1'b1; @(negedge clk); bus.tick = 1'b0;
        end
    endtask

    task automatic key(input logic [7:0] c, input bit with_tick);
        bus.key_valid = 1'b1; bus.key_char = c; bus.tick = with_tick;
        @(negedge clk);
        bus.key_valid = 1'b0; bus.tick = 1'b0;
    endtask

    task automatic read_slot(input int i);
        bus.rd_idx = 4'(i); @(negedge clk);
    endtask

    task automatic new_game();
        rst = 1'b0; @(negedge clk); rst = 1'b1; @(negedge clk);
        pulse_start();
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        rst = 1'b0;
        bus.start = 0; bus.spawn_valid = 0; bus.spawn_char = 0; bus.spawn_x = 0;
        bus.spawn_speed = 0; bus.tick = 0; bus.key_valid = 0; bus.key_char = 0; bus.rd_idx = 0;
        @(negedge clk);
        chk("reset state", 32'(bus.state), 0);
        chk("reset lives", 32'(bus.lives), 3);
        chk("reset score", 32'(bus.score), 0);
        chk("reset spawn_ready", 32'(bus.spawn_ready), 0);
        rst = 1'b1;
        @(negedge clk);
        pulse_start();
        chk("start state", 32'(bus.state), 1);
        chk("start lives", 32'(bus.lives), 3);
        chk("start score", 32'(bus.score), 0);
        chk("start spawn_ready", 32'(bus.spawn_ready), 1);
        for (int i = 0; i < 16; i++) begin
            read_slot(i);
            chk("empty rd_active", 32'(bus.rd_active), 0);
        end

        // 'A' at x=100, speed 4, three ticks -> y=12
        spawn(8'h41, 100, 4);
        ticks(3);
        read_slot(0);
        chk("A rd_active", 32'(bus.rd_active), 1);
        chk("A rd_char", 32'(bus.rd_char), 32'h41);
        chk("A rd_x", 32'(bus.rd_x), 100);
        chk("A rd_y", 32'(bus.rd_y), 12);

        // Two 'B's at y=20 (slot 0) and y=8 (slot 1): the deeper one is hit
        new_game();
        spawn(8'h42, 10, 4);
        ticks(3);
        spawn(8'h42, 20, 4);
        ticks(2);
        read_slot(0);
        chk("B0 rd_y", 32'(bus.rd_y), 20);
        read_slot(1);
        chk("B1 rd_y", 32'(bus.rd_y), 8);
        key(8'h42, 1'b0);
        chk("B hit", 32'(bus.hit), 1);
        chk("B score", 32'(bus.score), 1);
        read_slot(0);
        chk("B0 removed", 32'(bus.rd_active), 0);
        read_slot(1);
        chk("B1 kept", 32'(bus.rd_active), 1);
        chk("B1 kept y", 32'(bus.rd_y), 8);

        // Fill all 16 slots (speeds include 0), then free one
        for (int i = 0; i < 15; i++) spawn(8'h61 + 8'(i), i * 40, i % 8);
        chk("full spawn_ready", 32'(bus.spawn_ready), 0);
        spawn(8'h5a, 0, 1);
        key(8'h42, 1'b0);
        chk("freed spawn_ready", 32'(bus.spawn_ready), 1);

        // Single miss from y=476, speed 4
        new_game();
        spawn(8'h4d, 0, 4);
        ticks(119);
        read_slot(0);
        chk("M rd_y", 32'(bus.rd_y), 476);
        ticks(1);
        chk("M miss", 32'(bus.miss), 1);
        chk("M lives", 32'(bus.lives), 2);

        // Key and crossing tick in the same cycle: hit wins, no miss
        spawn(8'h4b, 0, 4);
        ticks(119);
        key(8'h4b, 1'b1);
        chk("K hit", 32'(bus.hit), 1);
        chk("K miss", 32'(bus.miss), 0);
        chk("K lives", 32'(bus.lives), 2);
        chk("K score", 32'(bus.score), 1);

        // Two slots crossing on one tick: 3 -> 1
        new_game();
        spawn(8'h50, 0, 7);
        spawn(8'h51, 0, 7);
        ticks(69);
        chk("PQ miss", 32'(bus.miss), 1);
        chk("PQ lives", 32'(bus.lives), 1);

        // Three crossing with one life left saturates to 0; a slow 'V' survives
        spawn(8'h52, 0, 7);
        spawn(8'h53, 0, 7);
        spawn(8'h54, 0, 7);
        spawn(8'h56, 33, 1);
        ticks(69);
        chk("RST lives", 32'(bus.lives), 0);
        chk("RST state", 32'(bus.state), 2);
        chk("RST game_over", 32'(bus.game_over), 1);

        // OVER: spawn, tick and key are ignored
        spawn(8'h55, 5, 1);
        ticks(2);
        key(8'h56, 1'b0);
        chk("over hit", 32'(bus.hit), 0);
        read_slot(3);
        chk("over V active", 32'(bus.rd_active), 1);
        chk("over V char", 32'(bus.rd_char), 32'h56);
        chk("over V y", 32'(bus.rd_y), 69);
        chk("over score", 32'(bus.score), 0);
        chk("over spawn_ready", 32'(bus.spawn_ready), 0);
        pulse_start();
        chk("over->idle state", 32'(bus.state), 0);
        chk("idle game_over", 32'(bus.game_over), 0);
        pulse_start();
        chk("replay state", 32'(bus.state), 1);
        chk("replay score", 32'(bus.score), 0);
        chk("replay lives", 32'(bus.lives), 3);

        // Asynchronous reset mid-game
        spawn(8'h57, 1, 1);
        ticks(2);
        key(8'h57, 1'b0);
        spawn(8'h58, 9, 2);
        read_slot(0);
        chk("pre-rst rd_char", 32'(bus.rd_char), 32'h58);
        rst = 1'b0;
        #1;
        chk("rst state", 32'(bus.state), 0);
        chk("rst score", 32'(bus.score), 0);
        chk("rst lives", 32'(bus.lives), 3);
        chk("rst hit", 32'(bus.hit), 0);
        chk("rst miss", 32'(bus.miss), 0);
        chk("rst rd_active", 32'(bus.rd_active), 0);
        chk("rst rd_char", 32'(bus.rd_char), 0);
        chk("rst rd_x", 32'(bus.rd_x), 0);
        chk("rst spawn_ready", 32'(bus.spawn_ready), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
